// File: rtl/inst_fifo_pkg.sv
// Shared CPU types for the instruction FIFO: address and instruction words,
// the stored entry layout, and the default superscalar width.
package inst_fifo_pkg;

  localparam int ISSUE_NUM = 2;
  localparam int XLEN      = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [31:0]     inst_t;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fifo_entry_t;

endpackage

// File: rtl/inst_fifo_prefix_count.sv
// prefix_count: length of the run of ones starting at bit 0 of vec.
// Used to turn per-lane valid/enable vectors into an in-order lane count.
module prefix_count #(
  parameter int W = 2
) (
  input  logic [W-1:0]           vec,
  output logic [$clog2(W+1)-1:0] len
);

  localparam int LW = $clog2(W + 1);

  // Walk lanes from 0 upward; the run only grows while every earlier lane was set.
  always_comb begin
    // NOTE: blocking assignments here, so each iteration sees the run length
    // produced by the previous one; sequential blocks use <= instead.
    len = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i] && (len == LW'(i))) len = LW'(i + 1);
    end
  end

endmodule

// File: rtl/inst_fifo.sv
// inst_fifo: multi-lane circular instruction buffer between fetch and issue.
// Up to FETCH_W lanes pushed and ISSUE_W lanes popped per cycle, in order.
// Optional feature: define INST_FIFO_BYPASS_EN to forward accepted push lanes
// straight to out_* in the same cycle while the FIFO is empty.
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int FETCH_W = ISSUE_NUM,
  parameter int ISSUE_W = ISSUE_NUM,
  parameter int DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [FETCH_W-1:0]      push_valid,
  input  addr_t [FETCH_W-1:0]     push_pc,
  input  inst_t [FETCH_W-1:0]     push_inst,
  output logic                    push_ready,
  input  logic [ISSUE_W-1:0]      issue_en,
  output logic [ISSUE_W-1:0]      out_valid,
  output addr_t [ISSUE_W-1:0]     out_pc,
  output inst_t [ISSUE_W-1:0]     out_inst,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PL_W  = $clog2(FETCH_W + 1);
  localparam int IL_W  = $clog2(ISSUE_W + 1);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_step;
  logic [PTR_W-1:0] tail_step;
  logic [CNT_W-1:0] count_nxt;
  logic [PL_W-1:0]  push_len;
  logic [PL_W-1:0]  n_push;
  logic [IL_W-1:0]  n_pop;
  logic [IL_W-1:0]  skip;
  logic             bypass_active;

  // Headroom is judged on the registered count, before any same-cycle pop.
  assign push_ready = (int'(count) <= DEPTH - FETCH_W);
  assign empty      = (count == '0);
  assign full       = (int'(count) == DEPTH);

  prefix_count #(.W(FETCH_W)) u_push_len (
    .vec (push_valid),
    .len (push_len)
  );

  assign n_push = push_ready ? push_len : '0;

  // Only lanes that currently show an entry may be popped, in order from lane 0.
  prefix_count #(.W(ISSUE_W)) u_pop_len (
    .vec (issue_en & out_valid),
    .len (n_pop)
  );

`ifdef INST_FIFO_BYPASS_EN
  assign bypass_active = (count == '0);
`else
  assign bypass_active = 1'b0;
`endif

  // Bypassed lanes that are popped never touch storage, so the head stays put
  // and the tail only advances over the lanes that are really written.
  assign skip      = bypass_active ? n_pop : '0;
  assign head_step = bypass_active ? '0 : PTR_W'(n_pop);
  assign tail_step = PTR_W'(n_push) - PTR_W'(skip);
  assign count_nxt = count + CNT_W'(n_push) - CNT_W'(n_pop);

  // Head lanes are valid when backed by storage, or by accepted pushes when bypassing.
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (bypass_active) out_valid[i] = (int'(n_push) > i);
      else               out_valid[i] = (int'(count) > i);
    end
  end

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_out
    fifo_entry_t stored;
    assign stored = mem[head + PTR_W'(g)];
    if (g < FETCH_W) begin : g_fwd
      assign out_pc[g]   = bypass_active ? push_pc[g]   : stored.pc;
      assign out_inst[g] = bypass_active ? push_inst[g] : stored.inst;
    end else begin : g_mem
      assign out_pc[g]   = stored.pc;
      assign out_inst[g] = stored.inst;
    end
  end

  // Pointer and occupancy registers; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments for all clocked state, so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + head_step;
      tail  <= tail + tail_step;
      count <= count_nxt;
    end
  end

  // Write accepted lanes at the tail, skipping lanes consumed by the bypass.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; valid data is tracked solely by
    // head/tail/count, which keeps the array a plain RAM.
    if (!flush) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i >= int'(skip) && i < int'(n_push)) begin
          mem[tail + PTR_W'(i) - PTR_W'(skip)] <= '{pc: push_pc[i], inst: push_inst[i]};
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo (FETCH_W=2, ISSUE_W=2, DEPTH=8).
// A queue-based reference model tracks the entries the FIFO should hold.
module tb_inst_fifo;
  import inst_fifo_pkg::*;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int D  = 8;
  localparam int CW = $clog2(D) + 1;
`ifdef INST_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic [FW-1:0]      push_valid = '0;
  addr_t [FW-1:0]     push_pc;
  inst_t [FW-1:0]     push_inst;
  logic               push_ready;
  logic [IW-1:0]      issue_en = '0;
  logic [IW-1:0]      out_valid;
  addr_t [IW-1:0]     out_pc;
  inst_t [IW-1:0]     out_inst;
  logic [CW-1:0]      count;
  logic               empty;
  logic               full;

  int errors = 0;
  int checks = 0;
  fifo_entry_t q[$];

  always #5 clk = ~clk;

  inst_fifo #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_inst  (push_inst),
    .push_ready (push_ready),
    .issue_en   (issue_en),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  // ---------------- reference model ----------------
  function automatic int lead(input logic [1:0] v);
    int n = 0;
    while (n < 2 && v[n]) n++;
    return n;
  endfunction

  function automatic int exp_push();
    return (D - q.size() >= FW) ? lead(push_valid) : 0;
  endfunction

  function automatic int exp_vis();
    if (q.size() > 0 || !BYP) return (q.size() < IW) ? q.size() : IW;
    return exp_push();
  endfunction

  function automatic fifo_entry_t exp_lane(input int i);
    if (q.size() > 0 || !BYP) return q[i];
    return '{pc: push_pc[i], inst: push_inst[i]};
  endfunction

  function automatic int exp_pop();
    int n = lead(issue_en);
    int v = exp_vis();
    return (n < v) ? n : v;
  endfunction

  task automatic drive(input logic fl, input logic [1:0] pv, input addr_t pc0,
                       input addr_t pc1, input logic [1:0] ie);
    flush        = fl;
    push_valid   = pv;
    push_pc[0]   = pc0;
    push_pc[1]   = pc1;
    push_inst[0] = pc0 ^ 32'h5a5a_0000;
    push_inst[1] = pc1 ^ 32'h5a5a_0000;
    issue_en     = ie;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, '0, '0, 2'b00);
  endtask

  // Advance one clock and apply the same transaction to the model.
  task automatic tick();
    int np;
    int npop;
    fifo_entry_t pushed[$];
    np   = exp_push();
    npop = exp_pop();
    for (int i = 0; i < np; i++) pushed.push_back('{pc: push_pc[i], inst: push_inst[i]});
    @(posedge clk);
    if (flush) q.delete();
    else begin
      foreach (pushed[i]) q.push_back(pushed[i]);
      repeat (npop) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b0;
    idle();
    checks++; if (count !== '0)       begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", push_ready); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    drive(1'b0, 2'b11, 32'h100, 32'h104, 2'b00);
    tick();
    idle();
    checks++; if (out_valid !== 2'b11)       begin errors++; $display("FAIL basic_valid: got %b want 11", out_valid); end
    checks++; if (out_pc[0] !== 32'h100)     begin errors++; $display("FAIL basic_pc0: got %h want 100", out_pc[0]); end
    checks++; if (out_pc[1] !== 32'h104)     begin errors++; $display("FAIL basic_pc1: got %h want 104", out_pc[1]); end
    checks++; if (out_inst[1] !== (32'h104 ^ 32'h5a5a_0000)) begin errors++; $display("FAIL basic_inst1: got %h", out_inst[1]); end
    checks++; if (count !== CW'(2))          begin errors++; $display("FAIL basic_count: got %0d want 2", count); end
    drive(1'b0, 2'b00, '0, '0, 2'b11);
    tick();
    idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b11, 32'h300 + 8 * k, 32'h304 + 8 * k, 2'b00);
      tick();
    end
    idle();
    checks++; if (count !== CW'(8))     begin errors++; $display("FAIL fill_count: got %0d want 8", count); end
    checks++; if (full !== 1'b1)        begin errors++; $display("FAIL fill_full: got %b want 1", full); end
    checks++; if (push_ready !== 1'b0)  begin errors++; $display("FAIL fill_ready: got %b want 0", push_ready); end
    drive(1'b0, 2'b11, 32'hdead, 32'hbeef, 2'b00);
    tick();
    idle();
    checks++; if (count !== CW'(8)) begin errors++; $display("FAIL fill_ignored_count: got %0d want 8", count); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b00, '0, '0, 2'b11);
      checks++; if (out_pc[0] !== 32'h300 + 8 * k) begin errors++; $display("FAIL fill_order_pc0[%0d]: got %h want %h", k, out_pc[0], 32'h300 + 8 * k); end
      checks++; if (out_pc[1] !== 32'h304 + 8 * k) begin errors++; $display("FAIL fill_order_pc1[%0d]: got %h want %h", k, out_pc[1], 32'h304 + 8 * k); end
      tick();
    end
    idle();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_partial();
    drive(1'b0, 2'b10, 32'h510, 32'h514, 2'b00);
    tick();
    idle();
    checks++; if (count !== '0) begin errors++; $display("FAIL partial_push_count: got %0d want 0", count); end
    drive(1'b0, 2'b11, 32'h500, 32'h504, 2'b00);
    tick();
    drive(1'b0, 2'b00, '0, '0, 2'b10);
    tick();
    idle();
    checks++; if (count !== CW'(2))      begin errors++; $display("FAIL partial_pop_count: got %0d want 2", count); end
    checks++; if (out_pc[0] !== 32'h500) begin errors++; $display("FAIL partial_pop_pc0: got %h want 500", out_pc[0]); end
    drive(1'b0, 2'b00, '0, '0, 2'b11);
    tick();
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'b00, '0, '0, 2'b00);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 2'b11, 32'h400 + 8 * k, 32'h404 + 8 * k, 2'b00);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b00, '0, '0, 2'b11);
      tick();
    end
    drive(1'b0, 2'b11, 32'h420, 32'h424, 2'b00);
    tick();
    // Head now sits at index 6 holding 0x418..0x424.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 2'b11, 32'h428 + 8 * k, 32'h42c + 8 * k, 2'b11);
      checks++; if (out_pc[0] !== 32'h418 + 8 * k) begin errors++; $display("FAIL wrap_pc0[%0d]: got %h want %h", k, out_pc[0], 32'h418 + 8 * k); end
      checks++; if (out_pc[1] !== 32'h41c + 8 * k) begin errors++; $display("FAIL wrap_pc1[%0d]: got %h want %h", k, out_pc[1], 32'h41c + 8 * k); end
      checks++; if (count !== CW'(4))              begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 4", k, count); end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 2'b11, 32'h600, 32'h604, 2'b11);
    tick();
    idle();
    checks++; if (count !== '0)        begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL flush_empty: got %b want 1", empty); end
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b want 00", out_valid); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 2'b11, 32'h700 + 8 * k, 32'h704 + 8 * k, 2'b00);
      tick();
    end
    idle();
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_valid: got %b want 00", out_valid); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL rst_mid_empty: got %b want 1", empty); end
    checks++; if (count !== '0)        begin errors++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef INST_FIFO_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 2'b00, '0, '0, 2'b00);
    tick();
    drive(1'b0, 2'b11, 32'h200, 32'h204, 2'b01);
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bypass_valid0: got %b want 1", out_valid[0]); end
    checks++; if (out_pc[0] !== 32'h200) begin errors++; $display("FAIL bypass_pc0: got %h want 200", out_pc[0]); end
    tick();
    idle();
    checks++; if (count !== CW'(1))      begin errors++; $display("FAIL bypass_count: got %0d want 1", count); end
    checks++; if (out_pc[0] !== 32'h204) begin errors++; $display("FAIL bypass_next_pc0: got %h want 204", out_pc[0]); end
  endtask
`endif

  task automatic test_random();
    int nv;
    logic [1:0] ev;
    fifo_entry_t e;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 19) == 0), 2'($urandom), $urandom, $urandom, 2'($urandom));
      nv = exp_vis();
      for (int i = 0; i < IW; i++) ev[i] = (i < nv);
      checks++; if (count !== CW'(q.size()))               begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, count, q.size()); end
      checks++; if (out_valid !== ev)                      begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, ev); end
      checks++; if (push_ready !== (D - q.size() >= FW))   begin errors++; $display("FAIL rand_ready[%0d]: got %b", n, push_ready); end
      checks++; if (empty !== (q.size() == 0))             begin errors++; $display("FAIL rand_empty[%0d]: got %b", n, empty); end
      checks++; if (full !== (q.size() == D))              begin errors++; $display("FAIL rand_full[%0d]: got %b", n, full); end
      for (int i = 0; i < nv; i++) begin
        e = exp_lane(i);
        checks++; if (out_pc[i] !== e.pc)     begin errors++; $display("FAIL rand_pc[%0d][%0d]: got %h want %h", n, i, out_pc[i], e.pc); end
        checks++; if (out_inst[i] !== e.inst) begin errors++; $display("FAIL rand_inst[%0d][%0d]: got %h want %h", n, i, out_inst[i], e.inst); end
      end
      tick();
    end
  endtask

  initial begin
    push_pc   = '0;
    push_inst = '0;
    test_reset();
    test_basic();
    test_fill();
    test_partial();
    test_wrap();
    test_flush();
`ifdef INST_FIFO_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
